m_pseudo_dram_param: RTL and testbench
======================================

Name: m_pseudo_dram_param

Overview:
Parametrised behavioural data-memory model for the MIPSCORE testbench; it replaces the fixed 15-cycle pseudo DRAM.
- Configurable depth and independent read/write latencies.
- Honours per-byte write enables.
- Optionally stalls on writes.
- Pulses a read-valid strobe when read data lands.
- Sits between the core's D_* port and a word array; drives STALL back to the core.

Parameters:
ADDR_W, 32, width of i_addr (byte address)
MEM_AW, 11, word-index width; depth = 2**MEM_AW words (2048 default)
RD_LATENCY, 15, wait cycles after read accept before data is latched; 0 = no-stall registered read
WR_LATENCY, 0, wait cycles after write accept before commit; 0 = commit at accept edge, no stall
WAIT_W, 8, width of the latency down-counter; RD_LATENCY and WR_LATENCY must each be < 2**WAIT_W

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_addr  in  ADDR_W  byte address; word index = i_addr[MEM_AW+1:2], higher bits ignored (aliasing)
i_data  in  32  write data
i_we  in  4  byte write enables; lane k = bits 8k+7:8k
i_oe  in  1  read request
o_data  out  32  registered read data, holds until next read completes
o_rvalid  out  1  one-cycle pulse in the cycle o_data first shows new read data
o_stall  out  1  high while a request is in flight (state != IDLE)

Behaviour:
- Reset (i_rst high at an edge):
  - state=IDLE, wait counter=0, o_data=0, o_rvalid=0, o_stall=0.
  - Captured addr/data/be are cleared.
  - Memory array is not cleared.
  - Reset mid-operation drops the pending request; an uncommitted write is never performed.
- States: IDLE, RWAIT, WWAIT. o_stall = (state != IDLE), combinational from state only.
- Accept: requests are sampled only in IDLE and not in reset.
  - Write has priority: if i_we!=0 and i_oe are both high, only the write is accepted and the read is dropped.
  - Requests presented in RWAIT/WWAIT are ignored; the core holds them stable while stalled.
- Read, RD_LATENCY=N>0:
  - Accept edge: latch word index, counter<=N, go to RWAIT.
  - In RWAIT: counter>0 -> decrement; counter==0 -> o_data<=mem[idx], o_rvalid<=1, go to IDLE.
  - o_stall is high for N+1 cycles; o_data/o_rvalid update at the edge that ends the stall.
- Read, RD_LATENCY=0: no state change, o_stall stays 0; o_data<=mem[i_addr idx] and o_rvalid<=1 at the accept edge.
- Write, WR_LATENCY=0: at the accept edge, mem[idx] lanes with i_we[k]=1 take i_data lanes; other lanes keep their value. No stall.
- Write, WR_LATENCY=M>0:
  - Accept edge: latch idx, data and be; counter<=M; go to WWAIT.
  - Counter decrements; at counter==0 commit the byte-masked write and go to IDLE.
  - o_stall is high for M+1 cycles.
- o_rvalid is 0 in every cycle not listed above; writes never raise it.
- Read-after-write:
  - A read accepted in the cycle after a write commit returns the new data.
  - Memory read in RWAIT uses the latched idx, so writes cannot race it (none are accepted in RWAIT).
- Back-to-back: a new request may be accepted in the first IDLE cycle after a completion; there is no dead cycle beyond the stall.
- Array is combinationally read, synchronously written, 32-bit words; no initialisation beyond optional $readmemh by the bench.

Test Plan:
- Defaults; write 0xDEADBEEF to 0x40 with i_we=4'hF; then read 0x40 -> no stall on write; o_stall high 16 cycles; o_data=0xDEADBEEF with o_rvalid pulse at the 16th edge after accept.
- Byte lanes: mem[0x10]=0x11223344; write i_data=0xAABBCCDD, i_we=4'b0101 -> read returns 0x11BB33DD.
- RD_LATENCY=0, WR_LATENCY=0: write 0x5 to 0x8, read 0x8 next cycle -> o_stall never high; o_data=0x5 one edge after the read request.
- WR_LATENCY=3: write 0x77 to 0x20 -> o_stall high 4 cycles; mem unchanged until the last edge. Pulse i_rst during the 2nd stall cycle -> mem[0x20] unchanged, o_stall=0 next cycle, o_data=0.
- Simultaneous i_oe=1 and i_we=4'hF to 0x30 with data 0x9 -> write performed, no o_rvalid; a later read returns 0x9.
- Aliasing/requests during stall (MEM_AW=11): read 0x2040 returns mem at 0x40; changing i_addr/i_oe during RWAIT has no effect on the returned word.

Source files
------------

// File: rtl/m_pseudo_dram_param.sv
// m_pseudo_dram_param
// Behavioural data memory for the MIPSCORE testbench with configurable depth
// and independent read/write latencies. It sits on the core's D_* port and
// asks the core to stall while a request is in flight.
//
// Ports:
//   i_clk     clock; all state changes on the rising edge
//   i_rst     synchronous reset, active-high
//   i_addr    byte address; word index = i_addr[MEM_AW+1:2]; upper bits alias
//   i_data    write data
//   i_we      byte write enables; lane k covers bits 8k+7:8k
//   i_oe      read request
//   o_data    registered read data; holds until the next read completes
//   o_rvalid  one-cycle pulse in the cycle o_data first shows new read data
//   o_stall   high while a request is in flight (state != IDLE)

module m_pseudo_dram_param #(
    parameter int ADDR_W     = 32,
    parameter int MEM_AW     = 11,
    parameter int RD_LATENCY = 15,
    parameter int WR_LATENCY = 0,
    parameter int WAIT_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_data,
    input  logic [3:0]        i_we,
    input  logic              i_oe,
    output logic [31:0]       o_data,
    output logic              o_rvalid,
    output logic              o_stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        WWAIT = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** MEM_AW;
    localparam logic [WAIT_W-1:0] RD_CNT = WAIT_W'(RD_LATENCY);
    localparam logic [WAIT_W-1:0] WR_CNT = WAIT_W'(WR_LATENCY);

    logic [31:0] mem [0:DEPTH-1];

    state_t              state_q, state_n;
    logic [WAIT_W-1:0]   cnt_q, cnt_n;
    logic [MEM_AW-1:0]   idx_q, idx_n;
    logic [31:0]         wdata_q, wdata_n;
    logic [3:0]          be_q, be_n;

    logic [MEM_AW-1:0]   req_idx;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_widx;
    logic [31:0]         mem_wdata;
    logic [3:0]          mem_wbe;
    logic                rd_fire;
    logic [MEM_AW-1:0]   rd_idx;
    logic [31:0]         rd_word;

    // Address bits outside the word index are deliberately ignored, so
    // higher addresses alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0]};

    assign req_idx = i_addr[MEM_AW+1:2];
    assign rd_word = mem[rd_idx];
    assign o_stall = (state_q != IDLE);

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        idx_n     = idx_q;
        wdata_n   = wdata_q;
        be_n      = be_q;
        mem_we    = 1'b0;
        mem_widx  = idx_q;
        mem_wdata = wdata_q;
        mem_wbe   = be_q;
        rd_fire   = 1'b0;
        rd_idx    = idx_q;

        case (state_q)
            IDLE: begin
                // A write wins when both a write and a read are presented;
                // the read is simply dropped.
                if (i_we != 4'b0) begin
                    if (WR_LATENCY == 0) begin
                        mem_we    = 1'b1;
                        mem_widx  = req_idx;
                        mem_wdata = i_data;
                        mem_wbe   = i_we;
                    end else begin
                        idx_n   = req_idx;
                        wdata_n = i_data;
                        be_n    = i_we;
                        cnt_n   = WR_CNT;
                        state_n = WWAIT;
                    end
                end else if (i_oe) begin
                    if (RD_LATENCY == 0) begin
                        rd_fire = 1'b1;
                        rd_idx  = req_idx;
                    end else begin
                        idx_n   = req_idx;
                        cnt_n   = RD_CNT;
                        state_n = RWAIT;
                    end
                end
            end
            RWAIT: begin
                // Reads use the latched index, so bus changes while stalled
                // cannot affect the returned word.
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - WAIT_W'(1);
                end else begin
                    rd_fire = 1'b1;
                    state_n = IDLE;
                end
            end
            WWAIT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - WAIT_W'(1);
                end else begin
                    mem_we  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            o_data   <= '0;
            o_rvalid <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            idx_q    <= idx_n;
            wdata_q  <= wdata_n;
            be_q     <= be_n;
            o_rvalid <= rd_fire;
            if (rd_fire) begin
                o_data <= rd_word;
            end
        end
    end

    // The array has no reset; gating with i_rst guarantees that a write
    // interrupted by reset is never performed.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_m_pseudo_dram_param.sv
// tb_m_pseudo_dram_param
// Self-checking bench for m_pseudo_dram_param. Three instances cover the
// default latencies (RD 15 / WR 0), zero latencies (RD 0 / WR 0) and a
// stalling write (RD 2 / WR 3). Transactions come from a vector table; reset
// mid-write, requests changing during a read stall and back-to-back accesses
// are hand-written sequences.

module tb_m_pseudo_dram_param;

    logic        clk;
    logic        rst    [3];
    logic [31:0] addr   [3];
    logic [31:0] data   [3];
    logic [3:0]  we     [3];
    logic        oe     [3];
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        stall  [3];

    int checks = 0;
    int errors = 0;

    m_pseudo_dram_param #(.RD_LATENCY(15), .WR_LATENCY(0)) dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_addr(addr[0]), .i_data(data[0]),
        .i_we(we[0]), .i_oe(oe[0]), .o_data(rdata[0]), .o_rvalid(rvalid[0]),
        .o_stall(stall[0])
    );

    m_pseudo_dram_param #(.RD_LATENCY(0), .WR_LATENCY(0)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_addr(addr[1]), .i_data(data[1]),
        .i_we(we[1]), .i_oe(oe[1]), .o_data(rdata[1]), .o_rvalid(rvalid[1]),
        .o_stall(stall[1])
    );

    m_pseudo_dram_param #(.RD_LATENCY(2), .WR_LATENCY(3)) dut_c (
        .i_clk(clk), .i_rst(rst[2]), .i_addr(addr[2]), .i_data(data[2]),
        .i_we(we[2]), .i_oe(oe[2]), .o_data(rdata[2]), .o_rvalid(rvalid[2]),
        .o_stall(stall[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        logic        oe;
        int          exp_stall;
        logic        exp_rv;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int inst, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] w,
                                 input logic o);
        addr[inst] = a;
        data[inst] = d;
        we[inst]   = w;
        oe[inst]   = o;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents a request, holds it while stalled, then checks the stall
    // length, the completion outputs and that o_rvalid drops afterwards.
    task automatic runVector(input vec_t v);
        int cycles;
        applyStimulus(v.inst, v.addr, v.data, v.we, v.oe);
        step();
        cycles = 0;
        while (stall[v.inst] && cycles < 200) begin
            cycles++;
            step();
        end
        checkOutput({v.name, " stall_cycles"}, 32'(cycles), 32'(v.exp_stall));
        checkOutput({v.name, " rvalid"}, 32'(rvalid[v.inst]), 32'(v.exp_rv));
        if (v.exp_rv) begin
            checkOutput({v.name, " data"}, rdata[v.inst], v.exp_data);
        end
        applyStimulus(v.inst, 32'h0, 32'h0, 4'h0, 1'b0);
        step();
        checkOutput({v.name, " rvalid_drop"}, 32'(rvalid[v.inst]), 32'h0);
    endtask

    initial begin
        int cycles;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            applyStimulus(i, 32'h0, 32'h0, 4'h0, 1'b0);
        end

        // Directed vectors: {inst, addr, data, we, oe, stall cycles, rvalid, data, name}
        vecs.push_back('{0, 32'h40,   32'hDEADBEEF, 4'hF, 1'b0,  0, 1'b0, 32'h0,        "a_wr40"});
        vecs.push_back('{0, 32'h40,   32'h0,        4'h0, 1'b1, 16, 1'b1, 32'hDEADBEEF, "a_rd40"});
        vecs.push_back('{0, 32'h10,   32'h11223344, 4'hF, 1'b0,  0, 1'b0, 32'h0,        "a_wr10_full"});
        vecs.push_back('{0, 32'h10,   32'hAABBCCDD, 4'h5, 1'b0,  0, 1'b0, 32'h0,        "a_wr10_lanes"});
        vecs.push_back('{0, 32'h10,   32'h0,        4'h0, 1'b1, 16, 1'b1, 32'h11BB33DD, "a_rd10"});
        vecs.push_back('{0, 32'h30,   32'h9,        4'hF, 1'b1,  0, 1'b0, 32'h0,        "a_wr_rd_30"});
        vecs.push_back('{0, 32'h30,   32'h0,        4'h0, 1'b1, 16, 1'b1, 32'h9,        "a_rd30"});
        vecs.push_back('{0, 32'h2040, 32'h0,        4'h0, 1'b1, 16, 1'b1, 32'hDEADBEEF, "a_rd_alias"});
        vecs.push_back('{1, 32'h8,    32'h5,        4'hF, 1'b0,  0, 1'b0, 32'h0,        "b_wr8"});
        vecs.push_back('{1, 32'h8,    32'h0,        4'h0, 1'b1,  0, 1'b1, 32'h5,        "b_rd8"});
        vecs.push_back('{1, 32'hC,    32'h12345678, 4'hF, 1'b0,  0, 1'b0, 32'h0,        "b_wrC_full"});
        vecs.push_back('{1, 32'hC,    32'hFFFFFFFF, 4'h2, 1'b0,  0, 1'b0, 32'h0,        "b_wrC_lane1"});
        vecs.push_back('{1, 32'hC,    32'h0,        4'h0, 1'b1,  0, 1'b1, 32'h1234FF78, "b_rdC"});
        vecs.push_back('{2, 32'h20,   32'h77,       4'hF, 1'b0,  4, 1'b0, 32'h0,        "c_wr20"});
        vecs.push_back('{2, 32'h20,   32'h0,        4'h0, 1'b1,  3, 1'b1, 32'h77,       "c_rd20"});

        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_data%0d", i), rdata[i], 32'h0);
            checkOutput($sformatf("reset_rvalid%0d", i), 32'(rvalid[i]), 32'h0);
            checkOutput($sformatf("reset_stall%0d", i), 32'(stall[i]), 32'h0);
            rst[i] = 1'b0;
        end
        step();

        foreach (vecs[i]) begin
            runVector(vecs[i]);
        end

        // Reset in the second stall cycle of a delayed write: the write is
        // dropped, the stall clears and o_data returns to zero.
        applyStimulus(2, 32'h20, 32'h88, 4'hF, 1'b0);
        step();
        checkOutput("c_wr88_stall1", 32'(stall[2]), 32'h1);
        step();
        checkOutput("c_wr88_stall2", 32'(stall[2]), 32'h1);
        rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        applyStimulus(2, 32'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("c_rst_stall", 32'(stall[2]), 32'h0);
        checkOutput("c_rst_data", rdata[2], 32'h0);
        checkOutput("c_rst_rvalid", 32'(rvalid[2]), 32'h0);
        step();
        runVector('{2, 32'h20, 32'h0, 4'h0, 1'b1, 3, 1'b1, 32'h77, "c_rd20_after_rst"});

        // Requests changing during a read stall must not alter the result.
        applyStimulus(0, 32'h40, 32'h0, 4'h0, 1'b1);
        step();
        applyStimulus(0, 32'h10, 32'h0, 4'h0, 1'b0);
        cycles = 0;
        while (stall[0] && cycles < 200) begin
            cycles++;
            if (cycles == 5) applyStimulus(0, 32'h30, 32'h0, 4'h0, 1'b1);
            step();
        end
        applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("a_rwait_stall_cycles", 32'(cycles), 32'd16);
        checkOutput("a_rwait_rvalid", 32'(rvalid[0]), 32'h1);
        checkOutput("a_rwait_data", rdata[0], 32'hDEADBEEF);
        step();

        // Back-to-back write then read on the zero-latency instance.
        applyStimulus(1, 32'h8, 32'h66, 4'hF, 1'b0);
        step();
        checkOutput("b_b2b_wr_stall", 32'(stall[1]), 32'h0);
        applyStimulus(1, 32'h8, 32'h0, 4'h0, 1'b1);
        step();
        applyStimulus(1, 32'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("b_b2b_rvalid", 32'(rvalid[1]), 32'h1);
        checkOutput("b_b2b_data", rdata[1], 32'h66);
        step();
        checkOutput("b_b2b_data_hold", rdata[1], 32'h66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
